// File: rtl/product_accumulator.sv
// Frame accumulator behind a radix-4 multiplier: registers operand pairs,
// sums their products over a frame and presents the sum and beat count
// on a valid/ready output until it is consumed.

// Unsigned 7x7 -> 18-bit parallel radix-4 (Booth) multiplier.
module top (
  input  logic [6:0]  x,
  input  logic [6:0]  y,
  output logic [17:0] p
);

  logic [8:0]  y_ext;
  logic [17:0] x_ext;
  logic [17:0] pp;
  logic [17:0] p_sum;
  logic [2:0]  trip;

  // A zero above y's MSB keeps the top digit non-negative, so the
  // recoding stays exact for unsigned operands.
  assign y_ext = {1'b0, y, 1'b0};
  assign x_ext = {11'b0, x};

  // Recode y into four radix-4 digits and sum the shifted partial products.
  always_comb begin
    p_sum = '0;
    pp    = '0;
    trip  = '0;
    for (int i = 0; i < 4; i++) begin
      trip = y_ext[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = x_ext;
        3'b011:         pp = x_ext << 1;
        3'b100:         pp = -(x_ext << 1);
        3'b101, 3'b110: pp = -x_ext;
        default:        pp = '0;
      endcase
      p_sum = p_sum + (pp << (2*i));
    end
  end

  assign p = p_sum;

endmodule

module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [6:0]       x,
  input  logic [6:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [6:0]       op_x;
  logic [6:0]       op_y;
  logic             op_vld;
  logic             op_last;
  logic [17:0]      p;
  logic [ACC_W-1:0] product;
  logic [ACC_W:0]   sum_wide;
  logic             sat;
  logic             accept;
  logic             release_res;
  logic             unused_p_hi;

  top mult (
    .x (op_x),
    .y (op_y),
    .p (p)
  );

  // The largest product 127*127 fits in 14 bits; the upper product bits are always zero.
  assign product     = ACC_W'(p[13:0]);
  assign unused_p_hi = ^p[17:14];

  assign sum_wide    = {1'b0, acc} + {1'b0, product};
  assign sat         = sum_wide[ACC_W];
  assign accept      = in_valid && in_ready;
  assign release_res = (state == HOLD) && out_ready;

  // Operand register: capture an accepted beat, otherwise leave a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x    <= '0;
      op_y    <= '0;
      op_vld  <= 1'b0;
      op_last <= 1'b0;
    end else if (accept) begin
      op_x    <= x;
      op_y    <= y;
      op_vld  <= 1'b1;
      op_last <= in_last;
    end else begin
      op_vld  <= 1'b0;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (op_vld && op_last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Saturating frame sum, beat count and sticky overflow; cleared once the result is taken.
  always_ff @(posedge clk) begin
    if (rst || release_res) begin
      acc       <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else if (op_vld) begin
      acc       <= sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
      out_count <= (&out_count) ? out_count : out_count + CNT_W'(1);
      overflow  <= overflow | sat;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (ACC_W=16 so saturation is reachable).
module tb_product_accumulator;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int ACC_MAX = 65535;

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } result_t;

  typedef struct {
    logic [6:0]  x;
    logic [6:0]  y;
    logic        last;
    int          idle;
    logic [15:0] exp_acc;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [6:0]       x;
  logic [6:0]       y;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  int      num_checks = 0;
  int      num_errors = 0;
  bit      rand_ready = 1'b0;
  result_t exp_q[$];
  result_t mon_exp;
  vec_t    vec[13];

  product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .out_count (out_count),
    .overflow  (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance to the next falling edge; optionally randomise downstream backpressure.
  task automatic step_cycle();
    @(negedge clk);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one beat, hold it until accepted, then drop in_valid and scramble the inputs.
  task automatic applyStimulus(input logic [6:0] bx, input logic [6:0] by, input logic blast);
    int guard = 0;
    in_valid = 1'b1;
    x        = bx;
    y        = by;
    in_last  = blast;
    while (in_ready !== 1'b1 && guard < 200) begin
      step_cycle();
      guard++;
    end
    if (guard >= 200) begin
      num_checks++;
      num_errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    step_cycle();
    in_valid = 1'b0;
    x        = 7'($urandom);
    y        = 7'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Wait (bounded) until every expected result has been handed off.
  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      step_cycle();
      guard++;
    end
    checkOutput("result_delivered_pending", 32'(exp_q.size()), 0);
  endtask

  // Output monitor: compare each consumed result against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      checkOutput("in_ready_low_while_out_valid", 32'(in_ready), 0);
      if (out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          num_checks++;
          num_errors++;
          $display("[TB] FAIL unexpected_result: got acc %0d, expected no result", acc);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("result_acc", 32'(acc), 32'(mon_exp.acc));
          checkOutput("result_count", 32'(out_count), 32'(mon_exp.cnt));
          checkOutput("result_overflow", 32'(overflow), 32'(mon_exp.ovf));
        end
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  // Main test sequence.
  initial begin
    int       len;
    int       idle;
    int       sum;
    logic [6:0] bx;
    logic [6:0] by;

    vec[0]  = '{7'd3,   7'd5,   1'b0, 0, 16'd0,     8'd0, 1'b0};
    vec[1]  = '{7'd127, 7'd127, 1'b0, 0, 16'd0,     8'd0, 1'b0};
    vec[2]  = '{7'd0,   7'd100, 1'b1, 0, 16'd16144, 8'd3, 1'b0};
    vec[3]  = '{7'd127, 7'd127, 1'b0, 0, 16'd0,     8'd0, 1'b0};
    vec[4]  = '{7'd127, 7'd127, 1'b0, 0, 16'd0,     8'd0, 1'b0};
    vec[5]  = '{7'd127, 7'd127, 1'b0, 0, 16'd0,     8'd0, 1'b0};
    vec[6]  = '{7'd127, 7'd127, 1'b0, 0, 16'd0,     8'd0, 1'b0};
    vec[7]  = '{7'd127, 7'd127, 1'b1, 0, 16'd65535, 8'd5, 1'b1};
    vec[8]  = '{7'd1,   7'd1,   1'b1, 0, 16'd1,     8'd1, 1'b0};
    vec[9]  = '{7'd10,  7'd10,  1'b0, 0, 16'd0,     8'd0, 1'b0};
    vec[10] = '{7'd7,   7'd9,   1'b1, 3, 16'd163,   8'd2, 1'b0};
    vec[11] = '{7'd127, 7'd127, 1'b1, 1, 16'd16129, 8'd1, 1'b0};
    vec[12] = '{7'd0,   7'd0,   1'b1, 0, 16'd0,     8'd1, 1'b0};

    // Reset held for two cycles with random inputs.
    rst       = 1'b1;
    out_ready = 1'b0;
    repeat (2) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      x        = 7'($urandom);
      y        = 7'($urandom);
      @(negedge clk);
    end
    #1;
    checkOutput("reset_acc", 32'(acc), 0);
    checkOutput("reset_count", 32'(out_count), 0);
    checkOutput("reset_overflow", 32'(overflow), 0);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_in_ready", 32'(in_ready), 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    // Latency: back-to-back frame with out_ready high.
    out_ready = 1'b1;
    exp_q.push_back('{16'd16144, 8'd3, 1'b0});
    applyStimulus(7'd3, 7'd5, 1'b0);
    applyStimulus(7'd127, 7'd127, 1'b0);
    applyStimulus(7'd0, 7'd100, 1'b1);
    #1;
    checkOutput("latency_drain_out_valid", 32'(out_valid), 0);
    checkOutput("latency_drain_in_ready", 32'(in_ready), 0);
    step_cycle();
    #1;
    checkOutput("latency_hold_out_valid", 32'(out_valid), 1);
    checkOutput("latency_hold_acc", 32'(acc), 16144);
    step_cycle();
    #1;
    checkOutput("latency_after_out_valid", 32'(out_valid), 0);
    checkOutput("latency_after_in_ready", 32'(in_ready), 1);
    checkOutput("latency_after_acc", 32'(acc), 0);
    step_cycle();

    // Backpressure: result held for 5 cycles while garbage is driven at the input.
    out_ready = 1'b0;
    exp_q.push_back('{16'd16144, 8'd3, 1'b0});
    applyStimulus(7'd3, 7'd5, 1'b0);
    applyStimulus(7'd127, 7'd127, 1'b0);
    applyStimulus(7'd0, 7'd100, 1'b1);
    step_cycle();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      x        = 7'($urandom);
      y        = 7'($urandom);
      in_last  = 1'($urandom);
      #1;
      checkOutput("stall_out_valid", 32'(out_valid), 1);
      checkOutput("stall_in_ready", 32'(in_ready), 0);
      checkOutput("stall_acc", 32'(acc), 16144);
      checkOutput("stall_count", 32'(out_count), 3);
      step_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step_cycle();
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 1);
    checkOutput("release_acc", 32'(acc), 0);
    checkOutput("release_out_valid", 32'(out_valid), 0);
    checkOutput("release_pending", 32'(exp_q.size()), 0);
    step_cycle();

    // Table-driven frames: saturation, single beats, bubbles.
    for (int i = 0; i < 13; i++) begin
      repeat (vec[i].idle) step_cycle();
      if (vec[i].last) exp_q.push_back('{vec[i].exp_acc, vec[i].exp_cnt, vec[i].exp_ovf});
      applyStimulus(vec[i].x, vec[i].y, vec[i].last);
      if (vec[i].last) wait_drain();
    end

    // Reset in the middle of a frame, with a beat still in the operand register.
    applyStimulus(7'd50, 7'd50, 1'b0);
    applyStimulus(7'd50, 7'd50, 1'b0);
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    #1;
    checkOutput("midreset_acc", 32'(acc), 0);
    checkOutput("midreset_count", 32'(out_count), 0);
    checkOutput("midreset_in_ready", 32'(in_ready), 1);
    step_cycle();
    #1;
    checkOutput("midreset_inflight_dropped", 32'(acc), 0);
    exp_q.push_back('{16'd6, 8'd1, 1'b0});
    applyStimulus(7'd2, 7'd3, 1'b1);
    wait_drain();

    // Beat counter saturates at 255 while the sum keeps growing.
    exp_q.push_back('{16'd300, 8'd255, 1'b0});
    for (int i = 0; i < 300; i++) applyStimulus(7'd1, 7'd1, 1'(i == 299));
    wait_drain();

    // Random frames with random bubbles and backpressure against a plain-sum model.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 8);
      sum = 0;
      for (int b = 0; b < len; b++) begin
        bx   = ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom);
        by   = ($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom);
        idle = $urandom_range(0, 2);
        repeat (idle) step_cycle();
        sum = sum + int'(bx) * int'(by);
        if (b == len - 1)
          exp_q.push_back('{16'((sum > ACC_MAX) ? ACC_MAX : sum), 8'(len), 1'(sum > ACC_MAX)});
        applyStimulus(bx, by, 1'(b == len - 1));
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (3) step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
